fir_mac_sched: RTL and testbench

Round-robin scheduler that time-shares one complex MAC datapath (a shift-register bank plus a single complex multiply-accumulate) among NUM_CH independent I/Q channels.
- Picks an eligible channel and pops one sample into that channel's delay line.
- Applies per-channel decimation.
- Sequences TAPS multiply-accumulate cycles.
- Waits for the pipelined result, then writes it to the channel's output FIFO.
- Sits between the channel input/output FIFOs and the shared datapath; moves no sample data itself.

---
 rtl/fir_mac_sched_pkg.sv | 36 +++
 rtl/fir_mac_sched_arb.sv | 22 ++
 rtl/fir_mac_sched.sv | 160 ++++++++++++++++
 tb/tb_fir_mac_sched.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_mac_sched_pkg.sv
// Shared types and helpers for the round-robin FIR MAC scheduler.
package fir_mac_sched_pkg;

    localparam int TAP_W  = 7;
    localparam int MAX_CH = 16;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        MAC,
        WAIT,
        WRITE
    } state_e;

    typedef struct packed {
        logic       vld;
        logic [3:0] idx;
    } grant_t;

    // Requests above NUM_CH are zero, so a mod-16 search equals a mod-NUM_CH one.
    function automatic grant_t rr_pick(input logic [MAX_CH-1:0] req,
                                       input logic [3:0]        ptr);
        grant_t     g;
        logic [4:0] k;
        g = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            k = 5'(ptr) + 5'(i);
            if (req[k[3:0]]) begin
                g.vld = 1'b1;
                g.idx = k[3:0];
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/fir_mac_sched_arb.sv
// Combinational round-robin arbiter: request vector plus pointer to grant.
module fir_rr_arbiter
    import fir_mac_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic              gnt_vld_o,
    output logic [CH_W-1:0]   gnt_idx_o
);

    logic [MAX_CH-1:0] req_pad;
    grant_t            g;

    assign req_pad   = MAX_CH'(req_i);
    assign g         = rr_pick(req_pad, 4'(ptr_i));
    assign gnt_vld_o = g.vld;
    assign gnt_idx_o = CH_W'(g.idx);

endmodule

// File: rtl/fir_mac_sched.sv
// Round-robin scheduler time-sharing one complex MAC among NUM_CH channels.
// Define FIR_MAC_SCHED_STATS_EN to add per-channel output and stall counters.
module fir_mac_sched
    import fir_mac_sched_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int TAPS       = 20,
    parameter int DECIMATION = 1,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       x_empty,
    output logic [NUM_CH-1:0]       x_rd_en,
    input  logic [NUM_CH-1:0]       y_full,
    output logic [NUM_CH-1:0]       y_wr_en,
    output logic [CH_W-1:0]         mac_ch,
    output logic                    mac_shift,
    output logic                    mac_valid,
    output logic [TAP_W-1:0]        mac_tap,
    output logic                    mac_first,
    output logic                    mac_last,
    input  logic                    mac_done,
`ifdef FIR_MAC_SCHED_STATS_EN
    output logic [NUM_CH-1:0][15:0] stat_out_cnt,
    output logic [15:0]             stat_stall_cnt,
`endif
    output logic                    busy
);

    state_e           state_q, state_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [CH_W-1:0]  ptr_q, ptr_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [7:0]       dec_q [NUM_CH];
    logic [7:0]       dec_cur, dec_nxt;
    logic             dec_wr;
    logic [CH_W-1:0]  nxt_ptr;
    logic             gnt_vld;
    logic [CH_W-1:0]  gnt_idx;

    fir_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req_i     (~x_empty & ~y_full),
        .ptr_i     (ptr_q),
        .gnt_vld_o (gnt_vld),
        .gnt_idx_o (gnt_idx)
    );

    assign dec_cur = dec_q[ch_q];
    assign nxt_ptr = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : CH_W'(ch_q + 1'b1);
    assign mac_ch  = ch_q;
    assign busy    = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        ptr_d     = ptr_q;
        tap_d     = tap_q;
        dec_wr    = 1'b0;
        dec_nxt   = dec_cur;
        x_rd_en   = '0;
        y_wr_en   = '0;
        mac_shift = 1'b0;
        mac_valid = 1'b0;
        mac_tap   = '0;
        mac_first = 1'b0;
        mac_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    ch_d    = gnt_idx;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                x_rd_en[ch_q] = 1'b1;
                mac_shift     = 1'b1;
                dec_wr        = 1'b1;
                if (dec_cur == 8'(DECIMATION - 1)) begin
                    dec_nxt = '0;
                    tap_d   = '0;
                    state_d = MAC;
                end else begin
                    dec_nxt = dec_cur + 8'd1;
                    ptr_d   = nxt_ptr;
                    state_d = IDLE;
                end
            end
            MAC: begin
                mac_valid = 1'b1;
                mac_tap   = tap_q;
                mac_first = (tap_q == '0);
                mac_last  = (tap_q == TAP_W'(TAPS - 1));
                if (mac_last) begin
                    tap_d   = '0;
                    state_d = WAIT;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            WAIT: begin
                if (mac_done) state_d = WRITE;
            end
            WRITE: begin
                if (!y_full[ch_q]) begin
                    y_wr_en[ch_q] = 1'b1;
                    ptr_d         = nxt_ptr;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            ptr_q   <= '0;
            tap_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) dec_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
            tap_q   <= tap_d;
            for (int i = 0; i < NUM_CH; i++) begin
                if (dec_wr && ch_q == CH_W'(i)) dec_q[i] <= dec_nxt;
            end
        end
    end

`ifdef FIR_MAC_SCHED_STATS_EN
    logic [NUM_CH-1:0][15:0] out_cnt_q;
    logic [15:0]             stall_q;
    logic                    stall_now;

    assign stall_now = (state_q == WAIT) ||
                       (state_q == WRITE && y_full[ch_q]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt_q <= '0;
            stall_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (y_wr_en[i]) out_cnt_q[i] <= out_cnt_q[i] + 16'd1;
            end
            if (stall_now && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
        end
    end

    assign stat_out_cnt   = out_cnt_q;
    assign stat_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fir_mac_sched.sv
// Directed bench for fir_mac_sched: one TAPS=20 instance, one TAPS=1/DEC=4 instance.
module tb_fir_mac_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [3:0] a_xe, a_yf, a_rd, a_wr;
    logic [1:0] a_ch;
    logic [6:0] a_tap;
    logic       a_sh, a_v, a_f, a_l, a_busy;
    logic       a_done = 1'b0;
    logic [3:0] b_xe, b_yf, b_rd, b_wr;
    logic [1:0] b_ch;
    logic [6:0] b_tap;
    logic       b_sh, b_v, b_f, b_l, b_busy;
    logic       b_done = 1'b0;

    int a_push [4] = '{default: 0};
    int a_pop  [4] = '{default: 0};
    int b_push [4] = '{default: 0};
    int b_pop  [4] = '{default: 0};
    int a_dmode = 0;
    int a_dcnt  = 0;
    int b_dcnt  = 0;

    int         a_rd_cyc [$];
    logic [3:0] a_rd_val [$];
    int         a_wr_cyc [$];
    logic [3:0] a_wr_val [$];
    int         a_v_cyc  [$];
    logic [6:0] a_v_tap  [$];
    logic [1:0] a_v_ch   [$];
    logic [1:0] a_v_fl   [$];
    int         b_rd_cyc [$];
    int         b_v_cyc  [$];
    logic [1:0] b_v_fl   [$];
    int         b_wr_cyc [$];

    int         a_inv_bad = 0;
    int         b_inv_bad = 0;
    int         a_ch_bad  = 0;
    logic       a_pbusy   = 1'b0;
    logic [1:0] a_pch     = 2'd0;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_xe[i] = (a_push[i] == a_pop[i]);
            b_xe[i] = (b_push[i] == b_pop[i]);
        end
    end

    fir_mac_sched #(.NUM_CH(4), .TAPS(20), .DECIMATION(1)) u_a (
        .clk(clk), .rst(rst), .x_empty(a_xe), .x_rd_en(a_rd),
        .y_full(a_yf), .y_wr_en(a_wr), .mac_ch(a_ch), .mac_shift(a_sh),
        .mac_valid(a_v), .mac_tap(a_tap), .mac_first(a_f), .mac_last(a_l),
        .mac_done(a_done), .busy(a_busy)
    );

    fir_mac_sched #(.NUM_CH(4), .TAPS(1), .DECIMATION(4)) u_b (
        .clk(clk), .rst(rst), .x_empty(b_xe), .x_rd_en(b_rd),
        .y_full(b_yf), .y_wr_en(b_wr), .mac_ch(b_ch), .mac_shift(b_sh),
        .mac_valid(b_v), .mac_tap(b_tap), .mac_first(b_f), .mac_last(b_l),
        .mac_done(b_done), .busy(b_busy)
    );

    // Environment: FIFO pops, datapath done model, logging, invariants.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            a_dcnt  = 0;
            b_dcnt  = 0;
            a_done  = (a_dmode == 1);
            b_done  = 1'b0;
            a_pbusy = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (a_rd[i]) a_pop[i] = a_pop[i] + 1;
                if (b_rd[i]) b_pop[i] = b_pop[i] + 1;
            end
            if (a_rd != 0) begin
                a_rd_cyc.push_back(cyc);
                a_rd_val.push_back(a_rd);
            end
            if (a_wr != 0) begin
                a_wr_cyc.push_back(cyc);
                a_wr_val.push_back(a_wr);
            end
            if (a_v) begin
                a_v_cyc.push_back(cyc);
                a_v_tap.push_back(a_tap);
                a_v_ch.push_back(a_ch);
                a_v_fl.push_back({a_f, a_l});
            end
            if (b_rd != 0) b_rd_cyc.push_back(cyc);
            if (b_wr != 0) b_wr_cyc.push_back(cyc);
            if (b_v) begin
                b_v_cyc.push_back(cyc);
                b_v_fl.push_back({b_f, b_l});
            end
            if (a_rd != 0 && a_wr != 0) a_inv_bad++;
            if (b_rd != 0 && b_wr != 0) b_inv_bad++;
            if (a_pbusy && a_ch != a_pch) a_ch_bad++;
            a_pbusy = a_busy;
            a_pch   = a_ch;
            if (a_dmode == 1) begin
                a_done = 1'b1;
            end else begin
                if (a_l) a_dcnt = 3;
                else if (a_dcnt > 0) a_dcnt--;
                a_done = (a_dcnt == 1);
            end
            if (b_l) b_dcnt = 3;
            else if (b_dcnt > 0) b_dcnt--;
            b_done = (b_dcnt == 1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input bit use_b, input int n_wr, input string nm);
        int k = 0;
        while (((use_b ? b_wr_cyc.size() : a_wr_cyc.size()) < n_wr ||
                (use_b ? b_busy : a_busy)) && k < 2000) begin
            tick(1);
            k++;
        end
        n_assert++;
        if (k >= 2000) begin
            n_fail++;
            $display("FAIL %s_timeout: writes %0d, required %0d", nm,
                     use_b ? b_wr_cyc.size() : a_wr_cyc.size(), n_wr);
        end
    endtask

    task automatic test_reset;
        a_yf = 4'b0000;
        b_yf = 4'b0000;
        tick(3);
        n_assert++;
        if ({a_rd, a_wr, a_ch, a_sh, a_v, a_tap, a_f, a_l, a_busy} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_a: outputs %h, required 0",
                     {a_rd, a_wr, a_ch, a_sh, a_v, a_tap, a_f, a_l, a_busy});
        end
        n_assert++;
        if ({b_rd, b_wr, b_ch, b_sh, b_v, b_tap, b_f, b_l, b_busy} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_b: outputs %h, required 0",
                     {b_rd, b_wr, b_ch, b_sh, b_v, b_tap, b_f, b_l, b_busy});
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_single;
        int r0, v0, w0, bad;
        r0 = a_rd_cyc.size();
        v0 = a_v_cyc.size();
        w0 = a_wr_cyc.size();
        a_dmode   = 0;
        a_push[2] = a_push[2] + 1;
        wait_done(1'b0, w0 + 1, "single");
        n_assert++;
        if (a_rd_val.size() != r0 + 1 || a_rd_val[r0] !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_pop: %0d pops, required 1 pop of 0100",
                     a_rd_val.size() - r0);
        end
        n_assert++;
        if (a_v_cyc.size() - v0 != 20) begin
            n_fail++;
            $display("FAIL single_nvalid: %0d, required 20", a_v_cyc.size() - v0);
        end
        bad = 0;
        for (int i = 0; i < a_v_cyc.size() - v0; i++) begin
            if (a_v_tap[v0+i] !== 7'(i) || a_v_fl[v0+i] !== {i == 0, i == 19} ||
                a_v_ch[v0+i] !== 2'd2) bad++;
        end
        n_assert++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL single_taps: %0d bad tap cycles, required 0", bad);
        end
        n_assert++;
        if (a_wr_val.size() != w0 + 1 || a_wr_val[w0] !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_write: %0d writes, required 1 of 0100",
                     a_wr_val.size() - w0);
        end
        n_assert++;
        if (a_wr_cyc.size() <= w0 || a_rd_cyc.size() <= r0 ||
            a_wr_cyc[w0] - a_rd_cyc[r0] != 23) begin
            n_fail++;
            $display("FAIL single_latency: %0d, required 23",
                     (a_wr_cyc.size() > w0 && a_rd_cyc.size() > r0) ?
                     a_wr_cyc[w0] - a_rd_cyc[r0] : -1);
        end
        n_assert++;
        if (a_v_cyc.size() <= v0 || a_rd_cyc.size() <= r0 ||
            a_v_cyc[v0] != a_rd_cyc[r0] + 1) begin
            n_fail++;
            $display("FAIL single_first_mac: mac not right after shift");
        end
    endtask

    task automatic test_rr;
        int r0, w0, bad;
        logic [3:0] exp_o [8];
        exp_o = '{4'b1000, 4'b0001, 4'b0010, 4'b0100,
                  4'b1000, 4'b0001, 4'b0010, 4'b0100};
        r0 = a_rd_cyc.size();
        w0 = a_wr_cyc.size();
        a_dmode = 1;
        for (int i = 0; i < 4; i++) a_push[i] = a_push[i] + 2;
        wait_done(1'b0, w0 + 8, "rr");
        for (int i = 0; i < 8; i++) begin
            n_assert++;
            if (a_rd_val.size() <= r0 + i || a_rd_val[r0+i] !== exp_o[i]) begin
                n_fail++;
                $display("FAIL rr_grant%0d: %b, required %b", i,
                         (a_rd_val.size() > r0 + i) ? a_rd_val[r0+i] : 4'bx,
                         exp_o[i]);
            end
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (a_wr_val.size() <= w0 + i || a_wr_val[w0+i] !== exp_o[i]) bad++;
        end
        n_assert++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rr_writes: %0d out of order, required 0", bad);
        end
        n_assert++;
        if (a_wr_cyc.size() <= w0 || a_rd_cyc.size() <= r0 ||
            a_wr_cyc[w0] - a_rd_cyc[r0] != 22) begin
            n_fail++;
            $display("FAIL rr_done_held_latency: required 22");
        end
    endtask

    task automatic test_yfull;
        int r0, w0;
        r0 = a_rd_cyc.size();
        w0 = a_wr_cyc.size();
        a_dmode   = 0;
        a_yf      = 4'b0010;
        a_push[1] = a_push[1] + 1;
        a_push[3] = a_push[3] + 1;
        wait_done(1'b0, w0 + 1, "yfull_ch3");
        tick(10);
        n_assert++;
        if (a_rd_val.size() != r0 + 1 || a_rd_val[r0] !== 4'b1000) begin
            n_fail++;
            $display("FAIL yfull_skip: %0d pops, required only 1000",
                     a_rd_val.size() - r0);
        end
        n_assert++;
        if (a_xe[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL yfull_ch1_kept: empty=%b, required 0", a_xe[1]);
        end
        a_yf = 4'b0000;
        wait_done(1'b0, w0 + 2, "yfull_ch1");
        n_assert++;
        if (a_rd_val.size() != r0 + 2 || a_rd_val[r0+1] !== 4'b0010 ||
            a_wr_val[w0+1] !== 4'b0010) begin
            n_fail++;
            $display("FAIL yfull_release: ch1 not served, pops %0d",
                     a_rd_val.size() - r0);
        end
    endtask

    task automatic test_write_stall;
        int w0, k;
        w0 = a_wr_cyc.size();
        a_push[0] = a_push[0] + 1;
        k = 0;
        while (!a_v && k < 100) begin
            tick(1);
            k++;
        end
        a_yf = 4'b0001;
        tick(40);
        n_assert++;
        if (a_wr_cyc.size() != w0 || a_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold: writes %0d busy %b, required 0 and 1",
                     a_wr_cyc.size() - w0, a_busy);
        end
        a_yf = 4'b0000;
        wait_done(1'b0, w0 + 1, "stall");
        n_assert++;
        if (a_wr_val.size() != w0 + 1 || a_wr_val[w0] !== 4'b0001) begin
            n_fail++;
            $display("FAIL stall_release: %0d writes, required 1 of 0001",
                     a_wr_val.size() - w0);
        end
    endtask

    task automatic test_reset_mid;
        int w0, v1, w1, k;
        w0 = a_wr_cyc.size();
        a_push[0] = a_push[0] + 1;
        k = 0;
        while (!(a_v && a_tap == 7'd7) && k < 100) begin
            tick(1);
            k++;
        end
        n_assert++;
        if (k >= 100) begin
            n_fail++;
            $display("FAIL rmid_reach_tap7: tap %0d, required 7", a_tap);
        end
        rst = 1'b1;
        #1;
        n_assert++;
        if ({a_rd, a_wr, a_ch, a_sh, a_v, a_tap, a_f, a_l, a_busy} !== 22'd0) begin
            n_fail++;
            $display("FAIL rmid_outputs: %h, required 0",
                     {a_rd, a_wr, a_ch, a_sh, a_v, a_tap, a_f, a_l, a_busy});
        end
        tick(2);
        rst = 1'b0;
        tick(40);
        n_assert++;
        if (a_wr_cyc.size() != w0 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_abandon: writes %0d busy %b, required 0 and 0",
                     a_wr_cyc.size() - w0, a_busy);
        end
        v1 = a_v_cyc.size();
        w1 = a_wr_cyc.size();
        a_push[0] = a_push[0] + 1;
        wait_done(1'b0, w1 + 1, "rmid_refill");
        n_assert++;
        if (a_v_cyc.size() != v1 + 20 || a_v_tap[v1] !== 7'd0 ||
            a_v_fl[v1] !== 2'b10) begin
            n_fail++;
            $display("FAIL rmid_fresh: %0d macs, required 20 from tap 0 with first",
                     a_v_cyc.size() - v1);
        end
    endtask

    task automatic test_decim;
        int r0, v0, w0;
        r0 = b_rd_cyc.size();
        v0 = b_v_cyc.size();
        w0 = b_wr_cyc.size();
        b_push[0] = b_push[0] + 8;
        wait_done(1'b1, w0 + 2, "decim");
        n_assert++;
        if (b_rd_cyc.size() - r0 != 8) begin
            n_fail++;
            $display("FAIL decim_pops: %0d, required 8", b_rd_cyc.size() - r0);
        end
        n_assert++;
        if (b_v_cyc.size() - v0 != 2) begin
            n_fail++;
            $display("FAIL decim_macs: %0d, required 2", b_v_cyc.size() - v0);
        end
        n_assert++;
        if (b_wr_cyc.size() - w0 != 2) begin
            n_fail++;
            $display("FAIL decim_writes: %0d, required 2", b_wr_cyc.size() - w0);
        end
        n_assert++;
        if (b_v_cyc.size() < v0 + 2 || b_v_fl[v0] !== 2'b11 ||
            b_v_fl[v0+1] !== 2'b11) begin
            n_fail++;
            $display("FAIL taps1_first_last: required first=last=1 on each mac");
        end
        n_assert++;
        if (b_v_cyc.size() < v0 + 2 || b_rd_cyc.size() < r0 + 8 ||
            b_v_cyc[v0] != b_rd_cyc[r0+3] + 1 ||
            b_v_cyc[v0+1] != b_rd_cyc[r0+7] + 1) begin
            n_fail++;
            $display("FAIL decim_mac_position: macs not after pops 4 and 8");
        end
    endtask

    task automatic test_invariants;
        n_assert++;
        if (a_inv_bad != 0 || b_inv_bad != 0) begin
            n_fail++;
            $display("FAIL rd_wr_overlap: %0d/%0d cycles, required 0",
                     a_inv_bad, b_inv_bad);
        end
        n_assert++;
        if (a_ch_bad != 0) begin
            n_fail++;
            $display("FAIL mac_ch_stable: %0d changes while busy, required 0",
                     a_ch_bad);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_rr;
        test_yfull;
        test_write_stall;
        test_reset_mid;
        test_decim;
        test_invariants;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
